// File: rtl/cl_seq_div.sv
// cl_seq_div: sequential carry-less (GF(2)) polynomial divider.
// Divides a 2*DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor using
// XOR long division, producing quotient and remainder.
//
// Optional build macro CL_SEQ_DIV_RADIX4_EN: when defined, the RUN state
// retires two dividend bits per cycle (two chained reduction steps), halving
// the RUN length. Results and DEG/FIN timing are identical in both builds.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE,
// which includes the done cycle). The accepting edge latches in_div_a and
// in_div_b; busy then stays high until the edge that raises done. done is a
// one-cycle pulse; out_quotient, out_remainder and div_by_zero are valid from
// that cycle and hold until the next operation's result is published.
module cl_seq_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   in_div_a,
    input  logic [DATA_WIDTH-1:0]     in_div_b,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero,
    output logic [2*DATA_WIDTH-1:0]   out_quotient,
    output logic [DATA_WIDTH-1:0]     out_remainder,
    output logic [1:0]                dbg_state
);

    localparam int QW    = 2 * DATA_WIDTH;
    localparam int DW_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNT_W = $clog2(QW);

`ifdef CL_SEQ_DIV_RADIX4_EN
    // Two bits per RUN cycle: DATA_WIDTH iterations.
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(DATA_WIDTH - 1);
`else
    // One bit per RUN cycle: 2*DATA_WIDTH iterations.
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(QW - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEG  = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [QW-1:0]          a_q, a_d;          // dividend, shifted left as bits are consumed
    logic [DATA_WIDTH-1:0]  b_q, b_d;          // divisor
    logic [DATA_WIDTH-1:0]  r_q, r_d;          // working remainder
    logic [QW-1:0]          q_q, q_d;          // quotient, shifted in MSB first
    logic [DW_W-1:0]        d_q, d_d;          // deg(b)
    logic [CNT_W-1:0]       cnt_q, cnt_d;      // remaining RUN iterations
    logic                   dz_q, dz_d;        // divisor was zero
    logic                   done_q, done_d;
    logic                   div_by_zero_q, div_by_zero_d;
    logic [QW-1:0]          out_quotient_q, out_quotient_d;
    logic [DATA_WIDTH-1:0]  out_remainder_q, out_remainder_d;

    logic [DW_W-1:0]        deg_calc;
    logic [DATA_WIDTH:0]    step1;             // {quotient bit, next remainder}
`ifdef CL_SEQ_DIV_RADIX4_EN
    logic [DATA_WIDTH:0]    step2;
`endif

    // One XOR long-division step: bring down one dividend bit and subtract
    // (XOR) the divisor when the aligned bit at position deg(b) is set.
    // Because deg(r) < deg(b), the shifted value never exceeds DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH:0] div_step(
        input logic [DATA_WIDTH-1:0] r,
        input logic                  a_bit,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DW_W-1:0]       d
    );
        logic [DATA_WIDTH-1:0] t;
        t = {r[DATA_WIDTH-2:0], a_bit};
        if (t[d]) begin
            return {1'b1, t ^ b};
        end
        return {1'b0, t};
    endfunction

    // Priority encoder: index of the highest set bit of the latched divisor.
    always_comb begin
        deg_calc = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (b_q[k]) begin
                deg_calc = DW_W'(k);
            end
        end
    end

    // Reduction datapath for the current RUN cycle.
    always_comb begin
        step1 = div_step(r_q, a_q[QW-1], b_q, d_q);
`ifdef CL_SEQ_DIV_RADIX4_EN
        step2 = div_step(step1[DATA_WIDTH-1:0], a_q[QW-2], b_q, d_q);
`endif
    end

    // Next-state and register-update logic for the IDLE/DEG/RUN/FIN sequence.
    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        r_d             = r_q;
        q_d             = q_q;
        d_d             = d_q;
        cnt_d           = cnt_q;
        dz_d            = dz_q;
        done_d          = 1'b0;
        div_by_zero_d   = div_by_zero_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_div_a;
                    b_d     = in_div_b;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_DEG;
                end
            end
            S_DEG: begin
                if (b_q == '0) begin
                    // Quotient and remainder stay at the zeros cleared on accept.
                    dz_d    = 1'b1;
                    state_d = S_FIN;
                end else begin
                    d_d     = deg_calc;
                    cnt_d   = RUN_LAST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef CL_SEQ_DIV_RADIX4_EN
                r_d = step2[DATA_WIDTH-1:0];
                q_d = {q_q[QW-3:0], step1[DATA_WIDTH], step2[DATA_WIDTH]};
                a_d = {a_q[QW-3:0], 2'b00};
`else
                r_d = step1[DATA_WIDTH-1:0];
                q_d = {q_q[QW-2:0], step1[DATA_WIDTH]};
                a_d = {a_q[QW-2:0], 1'b0};
`endif
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIN: begin
                out_quotient_d  = q_q;
                out_remainder_d = r_q;
                div_by_zero_d   = dz_q;
                done_d          = 1'b1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            r_q             <= '0;
            q_q             <= '0;
            d_q             <= '0;
            cnt_q           <= '0;
            dz_q            <= 1'b0;
            done_q          <= 1'b0;
            div_by_zero_q   <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            r_q             <= r_d;
            q_q             <= q_d;
            d_q             <= d_d;
            cnt_q           <= cnt_d;
            dz_q            <= dz_d;
            done_q          <= done_d;
            div_by_zero_q   <= div_by_zero_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign div_by_zero   = div_by_zero_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cl_seq_div.sv
// Testbench for cl_seq_div: one DATA_WIDTH=8 and one DATA_WIDTH=32 instance,
// directed cases plus random vectors checked against a polynomial long-division
// reference model and the identity a == clmul(q, b) ^ r.
module tb_cl_seq_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [15:0] a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dz8;
    logic [15:0] q8;
    logic [7:0]  r8;
    logic [1:0]  st8;

    logic        start32 = 1'b0;
    logic [63:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, dz32;
    logic [63:0] q32;
    logic [31:0] r32;
    logic [1:0]  st32;

    int n_checks = 0;
    int n_errors = 0;

    cl_seq_div #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in_div_a(a8), .in_div_b(b8),
        .busy(busy8), .done(done8), .div_by_zero(dz8),
        .out_quotient(q8), .out_remainder(r8), .dbg_state(st8)
    );

    cl_seq_div #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .in_div_a(a32), .in_div_b(b32),
        .busy(busy32), .done(done32), .div_by_zero(dz32),
        .out_quotient(q32), .out_remainder(r32), .dbg_state(st32)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int deg64(input logic [63:0] v);
        int d;
        d = -1;
        for (int k = 0; k < 64; k++) begin
            if (v[k]) d = k;
        end
        return d;
    endfunction

    // Textbook polynomial long division over GF(2).
    function automatic void ref_div(input logic [63:0] a, input logic [31:0] b, input int w,
                                    output logic [63:0] q, output logic [31:0] r);
        logic [63:0] rem;
        int db;
        rem = a;
        q   = '0;
        r   = '0;
        db  = deg64({32'b0, b});
        if (db < 0) return;
        for (int k = 2 * w - 1; k >= db; k--) begin
            if (rem[k]) begin
                rem      = rem ^ ({32'b0, b} << (k - db));
                q[k - db] = 1'b1;
            end
        end
        r = rem[31:0];
    endfunction

    function automatic logic [95:0] clmul(input logic [63:0] q, input logic [31:0] b);
        logic [95:0] p;
        p = '0;
        for (int k = 0; k < 32; k++) begin
            if (b[k]) p = p ^ ({32'b0, q} << k);
        end
        return p;
    endfunction

    function automatic int run_cycles(input int w);
`ifdef CL_SEQ_DIV_RADIX4_EN
        return w;
`else
        return 2 * w;
`endif
    endfunction

    // ---------------- DUT access ----------------
    task automatic drive(input bit w32, input logic [63:0] a, input logic [31:0] b, input logic s);
        if (w32) begin
            a32 = a; b32 = b; start32 = s;
        end else begin
            a8 = a[15:0]; b8 = b[7:0]; start8 = s;
        end
    endtask

    function automatic logic get_done(input bit w32);
        return w32 ? done32 : done8;
    endfunction

    function automatic logic get_busy(input bit w32);
        return w32 ? busy32 : busy8;
    endfunction

    // Last results observed by do_op, for directed constant checks.
    logic [63:0] last_q;
    logic [31:0] last_r;
    logic        last_dz;

    // ---------------- driver ----------------
    // Runs one division. sync=0 drives start right now (used in the done cycle).
    // inject_at>0 pulses start with operands ia/ib that many cycles after accept.
    task automatic do_op(input bit w32, input bit sync, input logic [63:0] a, input logic [31:0] b,
                         input int inject_at, input logic [63:0] ia, input logic [31:0] ib);
        int w;
        int lat;
        int exp_lat;
        bit overlap;
        logic [63:0] eq;
        logic [31:0] er;
        logic [95:0] prod;
        w = w32 ? 32 : 8;
        overlap = 1'b0;
        if (sync) @(negedge clk);
        drive(w32, a, b, 1'b1);
        @(posedge clk);
        #1;
        // Scramble operands after the accepting edge; they must not be re-read.
        drive(w32, ~a, ~b, 1'b0);
        check("busy_after_start", {95'b0, get_busy(w32)}, 96'd1);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (get_busy(w32) && get_done(w32)) overlap = 1'b1;
            if (get_done(w32)) break;
            if (lat >= 300) break;
            if (inject_at > 0 && lat == inject_at) drive(w32, ia, ib, 1'b1);
            else if (inject_at > 0 && lat == inject_at + 1) drive(w32, ~ia, ~ib, 1'b0);
        end
        exp_lat = (b == '0) ? 2 : run_cycles(w) + 2;
        check("latency", 96'(lat), 96'(exp_lat));
        check("busy_done_overlap", {95'b0, overlap}, 96'd0);
        check("busy_at_done", {95'b0, get_busy(w32)}, 96'd0);
        last_q  = w32 ? q32 : {48'b0, q8};
        last_r  = w32 ? r32 : {24'b0, r8};
        last_dz = w32 ? dz32 : dz8;
        ref_div(a, b, w, eq, er);
        check("quotient", {32'b0, last_q}, {32'b0, eq});
        check("remainder", {64'b0, last_r}, {64'b0, er});
        check("div_by_zero", {95'b0, last_dz}, {95'b0, (b == '0)});
        if (b != '0) begin
            prod = clmul(last_q, b) ^ {64'b0, last_r};
            check("identity", prod, {32'b0, a});
            check("rem_degree", {95'b0, (deg64({32'b0, last_r}) < deg64({32'b0, b}))}, 96'd1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] ra;
        logic [31:0] rb;
        int seen_done;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8", {95'b0, busy8}, 96'd0);
        check("rst_done8", {95'b0, done8}, 96'd0);
        check("rst_dz8", {95'b0, dz8}, 96'd0);
        check("rst_q8", {80'b0, q8}, 96'd0);
        check("rst_r8", {88'b0, r8}, 96'd0);
        check("rst_q32", {32'b0, q32}, 96'd0);
        check("rst_busy32", {95'b0, busy32}, 96'd0);
        rst = 1'b0;

        // Basic example, then done must be a single-cycle pulse
        do_op(1'b0, 1'b1, 64'h0022, 32'h0B, 0, '0, '0);
        check("ex1_q", {32'b0, last_q}, 96'h5);
        check("ex1_r", {64'b0, last_r}, 96'h5);
        @(posedge clk);
        #1;
        check("done_pulse_width", {95'b0, done8}, 96'd0);

        // Divisor 1 and divisor x^7
        do_op(1'b0, 1'b1, 64'hBEEF, 32'h01, 0, '0, '0);
        check("b1_q", {32'b0, last_q}, 96'hBEEF);
        check("b1_r", {64'b0, last_r}, 96'h0);
        do_op(1'b0, 1'b1, 64'hBEEF, 32'h80, 0, '0, '0);
        check("b80_q", {32'b0, last_q}, 96'h017D);
        check("b80_r", {64'b0, last_r}, 96'h6F);

        // Divide by zero, then a valid op clears the flag
        do_op(1'b0, 1'b1, 64'h1234, 32'h00, 0, '0, '0);
        check("dz_flag", {95'b0, last_dz}, 96'd1);
        do_op(1'b0, 1'b1, 64'h0022, 32'h0B, 0, '0, '0);
        check("dz_cleared", {95'b0, last_dz}, 96'd0);

        // start while busy is ignored; start in the done cycle is accepted
        do_op(1'b0, 1'b1, 64'h0022, 32'h0B, 5, 64'h0027, 32'h0B);
        check("ignored_q", {32'b0, last_q}, 96'h5);
        check("ignored_r", {64'b0, last_r}, 96'h5);
        do_op(1'b0, 1'b0, 64'h0027, 32'h0B, 0, '0, '0);
        check("b2b_q", {32'b0, last_q}, 96'h5);
        check("b2b_r", {64'b0, last_r}, 96'h0);

        // Reset in the middle of an operation
        @(negedge clk);
        drive(1'b0, 64'h0022, 32'h0B, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {95'b0, busy8}, 96'd0);
        check("midrst_done", {95'b0, done8}, 96'd0);
        check("midrst_q", {80'b0, q8}, 96'd0);
        check("midrst_r", {88'b0, r8}, 96'd0);
        check("midrst_dz", {95'b0, dz8}, 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done8) seen_done++;
        end
        check("midrst_no_done", 96'(seen_done), 96'd0);
        do_op(1'b0, 1'b1, 64'h0022, 32'h0B, 0, '0, '0);
        check("after_rst_q", {32'b0, last_q}, 96'h5);

        // Wide instance: directed corner cases
        do_op(1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 32'h0000_0000, 0, '0, '0);
        do_op(1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 32'h8000_0000, 0, '0, '0);
        do_op(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0001, 0, '0, '0);
        do_op(1'b1, 1'b1, 64'h0000_0000_0000_0001, 32'h0000_0003, 0, '0, '0);

        // Random vectors, non-zero divisors
        for (int n = 0; n < 600; n++) begin
            ra = {48'b0, 16'($urandom)};
            rb = {24'b0, 8'($urandom >> $urandom_range(0, 7))};
            if (rb == '0) rb = 32'h1;
            do_op(1'b0, 1'b1, ra, rb, 0, '0, '0);
        end
        for (int n = 0; n < 400; n++) begin
            ra = {$urandom, $urandom};
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'h1;
            do_op(1'b1, 1'b1, ra, rb, 0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
